// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one alu between two requesters
// Contains the shared alu datapath and the arbiter FSM around it.

module alu #(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       func,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   always_comb begin
      y = '0;
      case (func)
         4'd0: y = a + b;
         4'd1: y = a - b;
         4'd2: y = a & b;
         4'd3: y = a | b;
         4'd4: y = a ^ b;
         4'd5: y = a << b[SW-1:0];
         4'd6: y = a >> b[SW-1:0];
         4'd7: y[0] = (a < b);
         default: y = '0;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [3:0]       func0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   output logic             ack0,
   input  logic             req1,
   input  logic [3:0]       func1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack1,
   output logic [WIDTH-1:0] res,
   output logic             res_id,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state;
   logic             last_id;
   logic [3:0]       func_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] alu_y;
   logic             grant_id;

   // Port 1 wins only if port 0 is idle or port 0 held the previous grant.
   assign grant_id = !(req0 && (!req1 || last_id));
   assign busy     = (state != IDLE);

   alu #(.WIDTH(WIDTH)) u_alu (
      .func (func_r),
      .a    (a_r),
      .b    (b_r),
      .y    (alu_y)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         last_id   <= 1'b1;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         res_valid <= 1'b0;
         res       <= '0;
         res_id    <= 1'b0;
         func_r    <= '0;
         a_r       <= '0;
         b_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  func_r  <= grant_id ? func1 : func0;
                  a_r     <= grant_id ? a1 : a0;
                  b_r     <= grant_id ? b1 : b0;
                  last_id <= grant_id;
                  ack0    <= !grant_id;
                  ack1    <= grant_id;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               ack0      <= 1'b0;
               ack1      <= 1'b0;
               res       <= alu_y;
               res_id    <= last_id;
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter

module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1;
   logic [3:0]  func0, func1;
   logic [31:0] a0, b0, a1, b1;
   logic        ack0, ack1;
   logic [31:0] res;
   logic        res_id, res_valid, res_ready, busy;

   int checks = 0;
   int failures = 0;
   logic m_last;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .func0(func0), .a0(a0), .b0(b0), .ack0(ack0),
      .req1(req1), .func1(func1), .a1(a1), .b1(b1), .ack1(ack1),
      .res(res), .res_id(res_id), .res_valid(res_valid),
      .res_ready(res_ready), .busy(busy)
   );

   function automatic logic [31:0] model_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << (b % 32);
         4'd6: return a >> (b % 32);
         4'd7: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      m_last = 1'b1;
   endtask

   task automatic test_reset();
      req0 = 0; req1 = 0; func0 = 0; func1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; res_ready = 0;
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if ({res_valid, ack0, ack1, busy} !== 4'b0000 || res !== 32'd0) begin
            failures++;
            $display("FAIL reset_idle cycle %0d: valid=%b ack0=%b ack1=%b busy=%b res=%0d required all 0",
                     i, res_valid, ack0, ack1, busy, res);
         end
      end
   endtask

   // Single ADD on port 0; a0 is altered after capture to prove isolation.
   task automatic test_single_op(input logic change_after);
      res_ready = 1;
      func0 = 4'd0; a0 = 5; b0 = 7; req0 = 1;
      step();
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_capture: ack0=%b ack1=%b busy=%b valid=%b required 1 0 1 0", ack0, ack1, busy, res_valid);
      end
      req0 = 0;
      if (change_after) a0 = 99;
      step();
      checks++;
      if (ack0 !== 1'b0 || res_valid !== 1'b1 || res !== 32'd12 || res_id !== 1'b0) begin
         failures++;
         $display("FAIL single_result iso=%0d: ack0=%b valid=%b res=%0d id=%b required 0 1 12 0",
                  change_after, ack0, res_valid, res, res_id);
      end
      step();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || res !== 32'd12) begin
         failures++;
         $display("FAIL single_release: valid=%b busy=%b res=%0d required 0 0 12", res_valid, busy, res);
      end
      res_ready = 0;
      m_last = 1'b0;
   endtask

   task automatic test_round_robin();
      int n;
      logic exp_id;
      do_reset();
      res_ready = 1;
      func0 = 0; a0 = 1; b0 = 1; func1 = 0; a1 = 10; b1 = 10;
      req0 = 1; req1 = 1;
      n = 0;
      exp_id = 1'b0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         step();
         if (res_valid) begin
            checks++;
            if (res_id !== exp_id || res !== (exp_id ? 32'd20 : 32'd2)) begin
               failures++;
               $display("FAIL round_robin result %0d: id=%b res=%0d required id=%b res=%0d",
                        n, res_id, res, exp_id, exp_id ? 20 : 2);
            end
            exp_id = ~exp_id;
            n++;
         end
      end
      checks++;
      if (n != 4) begin
         failures++;
         $display("FAIL round_robin_count: got %0d results required 4", n);
      end
      req0 = 0; req1 = 0; res_ready = 0;
      step();
      step();
      step();
      m_last = 1'b1;
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      int n;
      do_reset();
      res_ready = 0;
      func0 = 0; a0 = 20; b0 = 22; req0 = 1;
      step();
      req0 = 0;
      func1 = 0; a1 = 3; b1 = 4; req1 = 1;
      n = 0;
      do begin step(); n++; end while (!res_valid && n < 10);
      held = res;
      checks++;
      if (res_valid !== 1'b1 || held !== 32'd42 || res_id !== 1'b0) begin
         failures++;
         $display("FAIL bp_first: valid=%b res=%0d id=%b required 1 42 0", res_valid, held, res_id);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (res !== 32'd42 || res_id !== 1'b0 || res_valid !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold %0d: res=%0d id=%b valid=%b ack1=%b busy=%b required 42 0 1 0 1",
                     i, res, res_id, res_valid, ack1, busy);
         end
      end
      res_ready = 1;
      step();
      res_ready = 0;
      checks++;
      if (res_valid !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_handshake: valid=%b ack1=%b busy=%b required 0 0 0", res_valid, ack1, busy);
      end
      step();
      checks++;
      if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
         failures++;
         $display("FAIL bp_next_grant: ack1=%b ack0=%b required 1 0", ack1, ack0);
      end
      req1 = 0;
      step();
      checks++;
      if (res_valid !== 1'b1 || res !== 32'd7 || res_id !== 1'b1) begin
         failures++;
         $display("FAIL bp_second: valid=%b res=%0d id=%b required 1 7 1", res_valid, res, res_id);
      end
      res_ready = 1;
      step();
      res_ready = 0;
      m_last = 1'b1;
   endtask

   task automatic test_reset_mid_op();
      func0 = 0; a0 = 5; b0 = 7; req0 = 1;
      step();
      req0 = 0;
      checks++;
      if (ack0 !== 1'b1) begin
         failures++;
         $display("FAIL midop_capture: ack0=%b required 1", ack0);
      end
      rst = 0;
      step();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
         failures++;
         $display("FAIL midop_abort: busy=%b valid=%b ack0=%b ack1=%b required 0 0 0 0", busy, res_valid, ack0, ack1);
      end
      rst = 1;
      m_last = 1'b1;
      step();
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midop_no_result: valid=%b busy=%b required 0 0", res_valid, busy);
      end
      req0 = 1; req1 = 1;
      step();
      checks++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
         failures++;
         $display("FAIL midop_tie: ack0=%b ack1=%b required 1 0", ack0, ack1);
      end
      req0 = 0; req1 = 0; res_ready = 1;
      step();
      step();
      res_ready = 0;
      m_last = 1'b0;
   endtask

   task automatic test_random();
      logic        exp_id;
      logic [31:0] exp_res;
      int          n, k;
      for (int it = 0; it < 30; it++) begin
         if (!req0 && $urandom_range(1, 0) == 1) begin
            func0 = 4'($urandom_range(9, 0)); a0 = $urandom; b0 = $urandom; req0 = 1;
         end
         if (!req1 && $urandom_range(1, 0) == 1) begin
            func1 = 4'($urandom_range(9, 0)); a1 = $urandom; b1 = $urandom; req1 = 1;
         end
         if (!req0 && !req1) begin
            func0 = 4'($urandom_range(9, 0)); a0 = $urandom; b0 = $urandom; req0 = 1;
         end
         exp_id  = (req0 && req1) ? ~m_last : req1;
         exp_res = exp_id ? model_alu(func1, a1, b1) : model_alu(func0, a0, b0);
         n = 0;
         do begin step(); n++; end while (!(ack0 || ack1) && n < 6);
         checks++;
         if (ack0 !== !exp_id || ack1 !== exp_id || n != 1) begin
            failures++;
            $display("FAIL rand_grant %0d: ack0=%b ack1=%b after %0d edges required id %b after 1", it, ack0, ack1, n, exp_id);
         end
         m_last = exp_id;
         if (exp_id) req1 = 0; else req0 = 0;
         step();
         checks++;
         if (res_valid !== 1'b1 || res !== exp_res || res_id !== exp_id) begin
            failures++;
            $display("FAIL rand_result %0d: valid=%b res=%h id=%b required 1 %h %b", it, res_valid, res, res_id, exp_res, exp_id);
         end
         k = $urandom_range(3, 0);
         for (int j = 0; j < k; j++) begin
            step();
            checks++;
            if (res_valid !== 1'b1 || res !== exp_res || res_id !== exp_id || ack0 !== 1'b0 || ack1 !== 1'b0) begin
               failures++;
               $display("FAIL rand_hold %0d: valid=%b res=%h id=%b required 1 %h %b", it, res_valid, res, res_id, exp_res, exp_id);
            end
         end
         res_ready = 1;
         step();
         res_ready = 0;
         checks++;
         if (res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rand_release %0d: valid=%b busy=%b required 0 0", it, res_valid, busy);
         end
      end
      req0 = 0; req1 = 0;
      step();
      step();
      step();
   endtask

   initial begin
      rst = 1'b0;
      m_last = 1'b1;
      test_reset();
      test_single_op(1'b0);
      test_single_op(1'b1);
      test_round_robin();
      test_backpressure();
      test_reset_mid_op();
      do_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
